mc_ctrl_fsm: RTL and testbench

- Multi-cycle sequencer for the MIPS-subset CPU datapath.
- Replaces the single-cycle opcode decoder. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines plus the PC/IR write strobes.
- Handles a shared instruction/data memory port with a ready handshake, so memory wait states stall the sequence.

---
 rtl/mc_ctrl_if.sv | 49 ++++
 rtl/mc_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave).
// With MC_CTRL_PERF_EN defined the bundle also carries the cycle and retired-instruction counters.
interface mc_ctrl_if #(
  parameter int OPW = 6,
  parameter int ACW = 3
);
  logic [OPW-1:0] op;
  logic           zero;
  logic           mem_rdy;
  logic           pcwr;
  logic           irwr;
  logic           memrd;
  logic           memwr;
  logic           regwr;
  logic           jump;
  logic           branch;
  logic           regdst;
  logic           alusrc;
  logic           memtoreg;
  logic           rtype;
  logic           extop;
  logic [ACW-1:0] aluctr;
  logic           illegal;
  logic [2:0]     state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0]    cycle_cnt;
  logic [31:0]    instret;
`endif

  // mem_rdy is the memory side's completion strobe for the access that memrd/memwr
  // is holding up; a request stays asserted at level until the cycle mem_rdy is 1.
  modport master (
    input  op, zero, mem_rdy,
    output pcwr, irwr, memrd, memwr, regwr, jump, branch,
    output regdst, alusrc, memtoreg, rtype, extop, aluctr, illegal, state
`ifdef MC_CTRL_PERF_EN
    , output cycle_cnt, instret
`endif
  );

  modport slave (
    output op, zero, mem_rdy,
    input  pcwr, irwr, memrd, memwr, regwr, jump, branch,
    input  regdst, alusrc, memtoreg, rtype, extop, aluctr, illegal, state
`ifdef MC_CTRL_PERF_EN
    , input cycle_cnt, instret
`endif
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Optional performance counters are enabled with MC_CTRL_PERF_EN.
module mc_ctrl_fsm #(
  parameter int OPW = 6,
  parameter int ACW = 3
) (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;

  localparam logic [ACW-1:0] ALU_ADD = 3'b000;
  localparam logic [ACW-1:0] ALU_SUB = 3'b001;
  localparam logic [ACW-1:0] ALU_OR  = 3'b010;
  localparam logic [ACW-1:0] ALU_FN  = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   illegal_q;

  logic is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_ori, is_legal;

  assign is_r     = (bus.op == OP_R);
  assign is_lw    = (bus.op == OP_LW);
  assign is_sw    = (bus.op == OP_SW);
  assign is_beq   = (bus.op == OP_BEQ);
  assign is_j     = (bus.op == OP_J);
  assign is_addi  = (bus.op == OP_ADDI);
  assign is_ori   = (bus.op == OP_ORI);
  assign is_legal = is_r | is_lw | is_sw | is_beq | is_j | is_addi | is_ori;

  // Static decode: purely a function of the opcode, valid in every state.
  assign bus.regdst   = is_r;
  assign bus.alusrc   = is_lw | is_sw | is_addi | is_ori;
  assign bus.memtoreg = is_lw;
  assign bus.rtype    = is_r;
  assign bus.extop    = is_lw | is_sw | is_addi | is_beq;

  always_comb begin
    bus.aluctr = ALU_ADD;
    if (is_r)        bus.aluctr = ALU_FN;
    else if (is_beq) bus.aluctr = ALU_SUB;
    else if (is_ori) bus.aluctr = ALU_OR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_d == S_TRAP);
    end
  end

  logic pcwr_c, irwr_c, memrd_c, memwr_c, regwr_c, jump_c, branch_c;

  always_comb begin
    state_d  = state_q;
    pcwr_c   = 1'b0;
    irwr_c   = 1'b0;
    memrd_c  = 1'b0;
    memwr_c  = 1'b0;
    regwr_c  = 1'b0;
    jump_c   = 1'b0;
    branch_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        if (bus.mem_rdy) begin
          irwr_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          state_d = S_TRAP;
        end else if (is_j) begin
          jump_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          branch_c = 1'b1;
          pcwr_c   = bus.zero;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_r || is_addi || is_ori) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // Request is held at level across wait states until the port completes.
        memrd_c = is_lw;
        memwr_c = is_sw;
        if (bus.mem_rdy) state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwr_c = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every strobe so an aborted instruction cannot write anything.
  assign bus.pcwr    = rst & pcwr_c;
  assign bus.irwr    = rst & irwr_c;
  assign bus.memrd   = rst & memrd_c;
  assign bus.memwr   = rst & memwr_c;
  assign bus.regwr   = rst & regwr_c;
  assign bus.jump    = rst & jump_c;
  assign bus.branch  = rst & branch_c;
  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_q, instret_q;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q == S_DECODE || state_q == S_EXEC ||
                   state_q == S_MEM    || state_q == S_WB);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else if (state_q != S_TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instret   = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction cycle scripts built from the ISA timing rules.
// Counter checks are compiled in when MC_CTRL_PERF_EN is defined.
module tb_mc_ctrl_fsm;
  // entry = {mem_rdy to drive, state[2:0], pcwr, irwr, memrd, memwr, regwr, jump, branch}
  localparam int W  = 11;
  localparam int OW = 19;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus.master));

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  int unsigned exp_cyc = 0;
  int unsigned exp_ret = 0;
  logic [5:0]  legal_ops [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};

  function automatic logic is_legal(input logic [5:0] op);
    is_legal = 1'b0;
    for (int i = 0; i < 7; i++) if (legal_ops[i] == op) is_legal = 1'b1;
  endfunction

  function automatic logic [7:0] exp_dec(input logic [5:0] op);
    logic [2:0] alu;
    alu = (op == OP_R) ? 3'b111 : (op == OP_BEQ) ? 3'b001 : (op == OP_ORI) ? 3'b010 : 3'b000;
    exp_dec = {op == OP_R, op == OP_LW || op == OP_SW || op == OP_ADDI || op == OP_ORI,
               op == OP_LW, op == OP_R, op == OP_LW || op == OP_SW || op == OP_ADDI || op == OP_BEQ, alu};
  endfunction

  function automatic logic [OW-1:0] full_exp(input logic [W-1:0] e, input logic [5:0] op);
    full_exp = {e[9:0], e[9:7] == 3'd5, exp_dec(op)};
  endfunction

  function automatic logic [W-1:0] ent(input logic rdy, input int st, input logic pcwr, input logic irwr,
                                       input logic memrd, input logic memwr, input logic regwr,
                                       input logic jump, input logic branch);
    ent = {rdy, 3'(st), pcwr, irwr, memrd, memwr, regwr, jump, branch};
  endfunction

  function automatic logic rnd();
    rnd = 1'($urandom_range(0, 1));
  endfunction

  // Cycle script of one instruction: fw fetch wait states, mw memory wait states.
  task automatic build(input logic [5:0] op, input logic z, input int fw, input int mw);
    logic lw, sw;
    lw = (op == OP_LW);
    sw = (op == OP_SW);
    for (int i = 0; i < fw; i++) exp_q.push_back(ent(0, 0, 0, 0, 1, 0, 0, 0, 0));
    exp_q.push_back(ent(1, 0, 1, 1, 1, 0, 0, 0, 0));
    if (!is_legal(op)) begin
      exp_q.push_back(ent(rnd(), 1, 0, 0, 0, 0, 0, 0, 0));
    end else if (op == OP_J) begin
      exp_q.push_back(ent(rnd(), 1, 1, 0, 0, 0, 0, 1, 0));
    end else begin
      exp_q.push_back(ent(rnd(), 1, 0, 0, 0, 0, 0, 0, 0));
      if (op == OP_BEQ) begin
        exp_q.push_back(ent(rnd(), 2, z, 0, 0, 0, 0, 0, 1));
      end else if (lw || sw) begin
        exp_q.push_back(ent(rnd(), 2, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) exp_q.push_back(ent(0, 3, 0, 0, lw, sw, 0, 0, 0));
        exp_q.push_back(ent(1, 3, 0, 0, lw, sw, 0, 0, 0));
        if (lw) exp_q.push_back(ent(rnd(), 4, 0, 0, 0, 0, 1, 0, 0));
      end else begin
        exp_q.push_back(ent(rnd(), 2, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(ent(rnd(), 4, 0, 0, 0, 0, 1, 0, 0));
      end
    end
  endtask

  // Drives one cycle of the script and returns what the DUT showed mid-cycle.
  task automatic cyc(input logic [W-1:0] e, output logic [OW-1:0] obs);
    bus.mem_rdy = e[10];
    @(negedge clk);
    obs = {bus.state, bus.pcwr, bus.irwr, bus.memrd, bus.memwr, bus.regwr, bus.jump, bus.branch,
           bus.illegal, bus.regdst, bus.alusrc, bus.memtoreg, bus.rtype, bus.extop, bus.aluctr};
    @(posedge clk);
    if (rst && e[9:7] != 3'd5) exp_cyc++;
    #1;
  endtask

  task automatic test_reset();
    bus.op = OP_R; bus.zero = 1'b0; bus.mem_rdy = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.illegal} !== 4'b0000) begin
      errors++; $display("FAIL reset_state got %b exp 0000", {bus.state, bus.illegal});
    end
    checks++;
    if ({bus.pcwr, bus.irwr, bus.memrd, bus.memwr, bus.regwr, bus.jump, bus.branch} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000000",
                         {bus.pcwr, bus.irwr, bus.memrd, bus.memwr, bus.regwr, bus.jump, bus.branch});
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (bus.cycle_cnt !== 32'd0 || bus.instret !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", bus.cycle_cnt, bus.instret);
    end
`endif
    @(posedge clk); #1;
    rst = 1'b1; exp_cyc = 0; exp_ret = 0;
  endtask

  task automatic test_rtype();
    logic [W-1:0] e; logic [OW-1:0] obs; int n = 0;
    bus.op = OP_R; bus.zero = rnd();
    build(OP_R, bus.zero, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cyc(e, obs); checks++;
      if (obs !== full_exp(e, bus.op)) begin
        errors++; $display("FAIL rtype cyc %0d got %h exp %h", n, obs, full_exp(e, bus.op));
      end
      n++;
    end
    exp_ret++;
  endtask

  task automatic test_lw_wait();
    logic [W-1:0] e; logic [OW-1:0] obs; int n = 0;
    bus.op = OP_LW; bus.zero = rnd();
    build(OP_LW, bus.zero, 0, 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cyc(e, obs); checks++;
      if (obs !== full_exp(e, bus.op)) begin
        errors++; $display("FAIL lw_wait cyc %0d got %h exp %h", n, obs, full_exp(e, bus.op));
      end
      n++;
    end
    exp_ret++;
  endtask

  task automatic test_beq();
    logic [W-1:0] e; logic [OW-1:0] obs;
    for (int z = 1; z >= 0; z--) begin
      bus.op = OP_BEQ; bus.zero = 1'(z);
      build(OP_BEQ, bus.zero, 0, 0);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); cyc(e, obs); checks++;
        if (obs !== full_exp(e, bus.op)) begin
          errors++; $display("FAIL beq zero=%0d got %h exp %h", z, obs, full_exp(e, bus.op));
        end
      end
      exp_ret++;
    end
  endtask

  task automatic test_j_sw();
    logic [W-1:0] e; logic [OW-1:0] obs;
    logic [5:0] ops [2] = '{OP_J, OP_SW};
    for (int k = 0; k < 2; k++) begin
      bus.op = ops[k]; bus.zero = rnd();
      build(ops[k], bus.zero, 0, k);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); cyc(e, obs); checks++;
        if (obs !== full_exp(e, bus.op)) begin
          errors++; $display("FAIL j_sw op=%b got %h exp %h", ops[k], obs, full_exp(e, bus.op));
        end
      end
      exp_ret++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e; logic [OW-1:0] obs;
    for (int k = 0; k < 60; k++) begin
      bus.op = legal_ops[$urandom_range(0, 6)]; bus.zero = rnd();
      build(bus.op, bus.zero, $urandom_range(0, 2), $urandom_range(0, 3));
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); cyc(e, obs); checks++;
        if (obs !== full_exp(e, bus.op)) begin
          errors++; $display("FAIL b2b instr %0d op=%b got %h exp %h", k, bus.op, obs, full_exp(e, bus.op));
        end
      end
      exp_ret++;
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (bus.cycle_cnt !== exp_cyc || bus.instret !== exp_ret) begin
      errors++; $display("FAIL b2b_perf got %0d/%0d exp %0d/%0d", bus.cycle_cnt, bus.instret, exp_cyc, exp_ret);
    end
`endif
  endtask

  task automatic test_trap();
    logic [W-1:0] e; logic [OW-1:0] obs; logic [5:0] op;
    op = 6'b111111;
    bus.op = op; bus.zero = rnd();
    build(op, bus.zero, 1, 0);
    for (int i = 0; i < 12; i++) exp_q.push_back(ent(rnd(), 5, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cyc(e, obs); checks++;
      if (obs !== full_exp(e, bus.op)) begin
        errors++; $display("FAIL trap got %h exp %h", obs, full_exp(e, bus.op));
      end
    end
    // A second trap with a random unsupported opcode after the counters are checked.
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (bus.cycle_cnt !== exp_cyc || bus.instret !== exp_ret) begin
      errors++; $display("FAIL trap_perf got %0d/%0d exp %0d/%0d", bus.cycle_cnt, bus.instret, exp_cyc, exp_ret);
    end
`endif
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1; exp_cyc = 0; exp_ret = 0;
    do op = 6'($urandom); while (is_legal(op));
    bus.op = op;
    build(op, bus.zero, 0, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(rnd(), 5, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); cyc(e, obs); checks++;
      if (obs !== full_exp(e, bus.op)) begin
        errors++; $display("FAIL trap_rand op=%b got %h exp %h", op, obs, full_exp(e, bus.op));
      end
    end
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1; exp_cyc = 0; exp_ret = 0;
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.illegal} !== 4'b0000) begin
      errors++; $display("FAIL trap_exit got %b exp 0000", {bus.state, bus.illegal});
    end
    @(posedge clk); exp_cyc++; #1;
  endtask

  task automatic test_reset_wb();
    logic [W-1:0] e; logic [OW-1:0] obs;
    bus.op = OP_ADDI; bus.zero = rnd();
    build(OP_ADDI, bus.zero, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[9:7] == 3'd4) begin
        rst = 1'b0; e[6:0] = 7'b0;
      end
      cyc(e, obs); checks++;
      if (obs !== full_exp(e, bus.op)) begin
        errors++; $display("FAIL reset_wb got %h exp %h", obs, full_exp(e, bus.op));
      end
    end
    rst = 1'b1; exp_cyc = 0; exp_ret = 0;
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.state, bus.regwr} !== 4'b0000) begin
      errors++; $display("FAIL reset_wb_after got %b exp 0000", {bus.state, bus.regwr});
    end
`ifdef MC_CTRL_PERF_EN
    checks++;
    if (bus.cycle_cnt !== 32'd0 || bus.instret !== 32'd0) begin
      errors++; $display("FAIL reset_wb_perf got %0d/%0d exp 0/0", bus.cycle_cnt, bus.instret);
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_j_sw();
    test_back_to_back();
    test_trap();
    test_reset_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
